mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 158 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- HI/LO register file and handshake controller for a
// multiply/divide unit. Multiply/divide operations issued from the E stage are
// latched and sent to an external arithmetic responder over a valid/ready
// request channel. The result comes back over a valid/ready response channel
// and is written into LO (res0) and HI (res1). mthi/mtlo write HI/LO directly
// from md_src_a without involving the responder.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   md_start/md_op/md_flush issue pulse, operation code, same-cycle cancel
//   md_src_a, md_src_b     rs / rt operands
//   md_use                 D-stage instruction depends on HI/LO or the unit
//   hi_out, lo_out         HI / LO registers
//   busy, stall            operation outstanding / pipeline stall request
//   req_*                  request channel to the responder
//   resp_*                 response channel from the responder
module mdu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              md_start,
  input  logic [2:0]        md_op,
  input  logic              md_flush,
  input  logic [DATA_W-1:0] md_src_a,
  input  logic [DATA_W-1:0] md_src_b,
  input  logic              md_use,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [1:0]        req_op,
  output logic              req_sign,
  output logic [DATA_W-1:0] req_src0,
  output logic [DATA_W-1:0] req_src1,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [DATA_W-1:0] resp_res0,
  input  logic [DATA_W-1:0] resp_res1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [1:0] ROP_IDLE = 2'b00;
  localparam logic [1:0] ROP_MUL  = 2'b01;
  localparam logic [1:0] ROP_DIV  = 2'b10;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic              sign_q;
  logic [DATA_W-1:0] src0_q, src1_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic              is_arith;
  logic [1:0]        dec_op;
  logic              dec_sign;
  logic              start_ok;
  logic              eff_start;
  logic              resp_fire;

  // Operation decode; undefined codes behave as "none".
  always_comb begin
    is_arith = 1'b0;
    dec_op   = ROP_IDLE;
    dec_sign = 1'b0;
    case (md_op)
      OP_MULT:  begin is_arith = 1'b1; dec_op = ROP_MUL; dec_sign = 1'b1; end
      OP_MULTU: begin is_arith = 1'b1; dec_op = ROP_MUL; dec_sign = 1'b0; end
      OP_DIV:   begin is_arith = 1'b1; dec_op = ROP_DIV; dec_sign = 1'b1; end
      OP_DIVU:  begin is_arith = 1'b1; dec_op = ROP_DIV; dec_sign = 1'b0; end
      default:  ;
    endcase
  end

  assign start_ok  = md_start & ~md_flush;
  // A start while an operation is outstanding is dropped entirely.
  assign eff_start = start_ok & (state_q == S_IDLE);
  assign resp_fire = (state_q == S_WAIT) & resp_valid;

  // Control: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control: next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eff_start && is_arith) state_d = S_REQ;
      end
      S_REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        resp_ready = 1'b1;
        if (resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch and HI/LO registers. Reset clears them so an operation
  // abandoned by reset leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= ROP_IDLE;
      sign_q <= 1'b0;
      src0_q <= '0;
      src1_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (eff_start && is_arith) begin
        op_q   <= dec_op;
        sign_q <= dec_sign;
        src0_q <= md_src_a;
        src1_q <= md_src_b;
      end
      if (eff_start && md_op == OP_MTHI) hi_q <= md_src_a;
      if (eff_start && md_op == OP_MTLO) lo_q <= md_src_a;
      if (resp_fire) begin
        lo_q <= resp_res0;
        hi_q <= resp_res1;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign stall    = md_use & (busy | (start_ok & is_arith));
  assign req_op   = req_valid ? op_q : ROP_IDLE;
  assign req_sign = sign_q;
  assign req_src0 = src0_q;
  assign req_src1 = src1_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: the bench plays the pipeline and the arithmetic
// responder, keeps a transaction-level model of HI/LO and the outstanding
// operation, and compares every output on every falling edge.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_flush;
  logic [31:0] md_src_a, md_src_b;
  logic        md_use;
  logic [31:0] hi_out, lo_out;
  logic        busy, stall;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic        req_sign;
  logic [31:0] req_src0, req_src1;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_res0, resp_res1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .reset(reset),
    .md_start(md_start), .md_op(md_op), .md_flush(md_flush),
    .md_src_a(md_src_a), .md_src_b(md_src_b), .md_use(md_use),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sign(req_sign), .req_src0(req_src0), .req_src1(req_src1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_res0(resp_res0), .resp_res1(resp_res1)
  );

  // Reference arithmetic: returns {res1, res0} = {HI, LO}.
  function automatic logic [63:0] golden(input logic [1:0] op, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    int              q, r;
    if (op == 2'b01) begin
      if (sgn) begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb;
        return sp;
      end
      ua = {32'h0, a}; ub = {32'h0, b}; up = ua * ub;
      return up;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Transaction-level model: phase 0 = nothing outstanding, 1 = request
  // pending acceptance, 2 = awaiting result.
  int          m_phase = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_s0 = '0, m_s1 = '0;
  logic [1:0]  m_op = '0;
  logic        m_sign = 1'b0;

  always @(posedge clk) begin
    logic [63:0] res;
    if (reset) begin
      m_phase = 0; m_hi = '0; m_lo = '0; m_s0 = '0; m_s1 = '0;
      m_op = '0; m_sign = 1'b0;
    end else if (m_phase == 0) begin
      if (md_start && !md_flush) begin
        if (md_op >= 3'd1 && md_op <= 3'd4) begin
          m_op    = (md_op <= 3'd2) ? 2'b01 : 2'b10;
          m_sign  = (md_op == 3'd1) || (md_op == 3'd3);
          m_s0    = md_src_a;
          m_s1    = md_src_b;
          m_phase = 1;
        end else if (md_op == 3'd5) m_hi = md_src_a;
        else if (md_op == 3'd6) m_lo = md_src_a;
      end
    end else if (m_phase == 1) begin
      if (req_ready) m_phase = 2;
    end else begin
      if (resp_valid) begin
        res = golden(m_op, m_sign, m_s0, m_s1);
        m_lo = res[31:0];
        m_hi = res[63:32];
        m_phase = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_stall;
    if (chk_en) begin
      exp_stall = md_use && (m_phase != 0 ||
                  (md_start && !md_flush && md_op >= 3'd1 && md_op <= 3'd4));
      check("busy", busy, m_phase != 0);
      check("req_valid", req_valid, m_phase == 1);
      check("req_op", req_op, (m_phase == 1) ? m_op : 2'b00);
      check("resp_ready", resp_ready, m_phase == 2);
      check("hi_out", hi_out, m_hi);
      check("lo_out", lo_out, m_lo);
      check("stall", stall, exp_stall);
      if (m_phase == 1) begin
        check("req_sign", req_sign, m_sign);
        check("req_src0", req_src0, m_s0);
        check("req_src1", req_src1, m_s1);
      end
    end
  end

  // One cycle of stimulus; returns #1 after the next rising edge.
  task automatic cyc(input logic st, input logic [2:0] op, input logic fl,
                     input logic [31:0] a, input logic [31:0] b, input logic use_i,
                     input logic rr, input logic rv, input logic rst);
    md_start = st; md_op = op; md_flush = fl; md_src_a = a; md_src_b = b;
    md_use = use_i; req_ready = rr; resp_valid = rv; reset = rst;
    if (m_phase == 2) {resp_res1, resp_res0} = golden(m_op, m_sign, m_s0, m_s1);
    else {resp_res1, resp_res0} = {$urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    chk_en = 1'b1;
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 0, 1);

    // Reset state and model pins
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_op", req_op, 2'b00);
    check("gold_div", golden(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("gold_mul", golden(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);

    // Signed divide at minimum latency
    cyc(1, 3'd3, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    check("div_busy_t1", busy, 1'b1);
    check("div_req_op", req_op, 2'b10);
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
    check("div_busy_t2", busy, 1'b1);
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    check("div_busy_t3", busy, 1'b0);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);

    // Unsigned divide
    cyc(1, 3'd4, 0, 32'd7, 32'd2, 0, 0, 0, 0);
    check("divu_req_op", req_op, 2'b10);
    check("divu_sign", req_sign, 1'b0);
    check("divu_valid", req_valid, 1'b1);
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    check("divu_lo", lo_out, 32'd3);
    check("divu_hi", hi_out, 32'd1);

    // mthi / mtlo
    cyc(1, 3'd5, 0, 32'h1234_5678, 32'h0, 0, 1, 1, 0);
    check("mthi_hi", hi_out, 32'h1234_5678);
    check("mthi_valid", req_valid, 1'b0);
    cyc(1, 3'd6, 0, 32'h9ABC_DEF0, 32'h0, 0, 1, 1, 0);
    check("mtlo_lo", lo_out, 32'h9ABC_DEF0);
    check("mtlo_hi", hi_out, 32'h1234_5678);
    check("mtlo_busy", busy, 1'b0);

    // Multiply under back-pressure on both channels
    cyc(1, 3'd1, 0, 32'hFFFF_FFFD, 32'd5, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_req", stall, 1'b1);
      check("bp_src0", req_src0, 32'hFFFF_FFFD);
      cyc(0, 3'd0, 0, $urandom, $urandom, 1, 0, 1, 0);
    end
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_stall_wait", stall, 1'b1);
      cyc(1, 3'd5, 0, $urandom, $urandom, 1, 1, 0, 0);
    end
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 1, 0, 1, 0);
    check("mult_lo", lo_out, 32'hFFFF_FFF1);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_busy", busy, 1'b0);

    // Flushed start
    cyc(1, 3'd3, 1, 32'd100, 32'd3, 0, 1, 1, 0);
    check("flush_busy", busy, 1'b0);
    check("flush_lo", lo_out, 32'hFFFF_FFF1);
    check("flush_hi", hi_out, 32'hFFFF_FFFF);

    // Reset while awaiting a result that arrives the same cycle
    cyc(1, 3'd3, 0, 32'd100, 32'd7, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
    check("rw_resp_ready", resp_ready, 1'b1);
    cyc(0, 3'd0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
    check("rw_hi", hi_out, 32'h0);
    check("rw_lo", lo_out, 32'h0);
    check("rw_busy", busy, 1'b0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom;
      cyc($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)),
          $urandom_range(0, 9) == 0, $urandom, b, 1'($urandom),
          $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4,
          $urandom_range(0, 199) == 0);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
